// File: rtl/scr1_dmem_tcm_resp.sv
// Tightly coupled data RAM responding on the core DMEM interface.
// Serves one byte/halfword/word access at a time with a fixed response latency.
module scr1_dmem_tcm_resp #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned LATENCY     = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dmem_req,
    input  logic        dmem_cmd,
    input  logic [1:0]  dmem_width,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wdata,
    output logic        dmem_req_ack,
    output logic [31:0] dmem_rdata,
    output logic [1:0]  dmem_resp
);

    localparam int unsigned AW       = $clog2(DEPTH_WORDS);
    localparam logic [1:0]  CNT_INIT = 2'(LATENCY - 1);

    localparam logic [1:0] RESP_IDLE = 2'd0;
    localparam logic [1:0] RESP_OK   = 2'd1;
    localparam logic [1:0] RESP_ER   = 2'd2;

    localparam logic [1:0] W_BYTE  = 2'd0;
    localparam logic [1:0] W_HWORD = 2'd1;
    localparam logic [1:0] W_WORD  = 2'd2;

    typedef enum logic {ST_IDLE, ST_BUSY} state_t;

    state_t          state, state_next;
    logic [1:0]      cnt, cnt_next;
    logic            cmd_q;
    logic [1:0]      width_q;
    logic [AW+1:0]   addr_q;
    logic [31:0]     wdata_q;
    logic            err_q;

    logic            accept;
    logic            resp_cycle;
    logic            in_range;
    logic            req_err;
    logic [AW-1:0]   idx;
    logic [3:0]      be;
    logic [31:0]     wdata_lanes;
    logic [31:0]     rd_word;
    logic [31:0]     rd_sel;

    logic [31:0]     mem [DEPTH_WORDS];

    assign dmem_req_ack = (state == ST_IDLE);
    assign accept       = dmem_req & dmem_req_ack;
    assign resp_cycle   = (state == ST_BUSY) && (cnt == 2'd0);

    // BASE_ADDR is aligned to the array size, so the range test is a tag compare
    assign in_range = (dmem_addr[31:AW+2] == BASE_ADDR[31:AW+2]);

    always_comb begin
        req_err = !in_range;
        case (dmem_width)
            W_BYTE:  ;
            W_HWORD: if (dmem_addr[0]) req_err = 1'b1;
            W_WORD:  if (dmem_addr[1:0] != 2'b00) req_err = 1'b1;
            default: req_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            cmd_q   <= 1'b0;
            width_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (accept) begin
                cmd_q   <= dmem_cmd;
                width_q <= dmem_width;
                addr_q  <= dmem_addr[AW+1:0];
                wdata_q <= dmem_wdata;
                err_q   <= req_err;
            end
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        dmem_resp  = RESP_IDLE;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_next = ST_BUSY;
                    cnt_next   = CNT_INIT;
                end
            end
            ST_BUSY: begin
                if (cnt != 2'd0) begin
                    cnt_next = cnt - 2'd1;
                end else begin
                    dmem_resp  = err_q ? RESP_ER : RESP_OK;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign idx = addr_q[AW+1:2];

    always_comb begin
        be          = 4'b0000;
        wdata_lanes = wdata_q;
        case (width_q)
            W_BYTE: begin
                be          = 4'b0001 << addr_q[1:0];
                wdata_lanes = {4{wdata_q[7:0]}};
            end
            W_HWORD: begin
                be          = addr_q[1] ? 4'b1100 : 4'b0011;
                wdata_lanes = {2{wdata_q[15:0]}};
            end
            W_WORD:  be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (resp_cycle && !err_q && cmd_q) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wdata_lanes[8*i +: 8];
            end
        end
    end

    assign rd_word = mem[idx];

    always_comb begin
        case (width_q)
            W_BYTE:  rd_sel = {24'b0, rd_word[8*addr_q[1:0] +: 8]};
            W_HWORD: rd_sel = {16'b0, addr_q[1] ? rd_word[31:16] : rd_word[15:0]};
            default: rd_sel = rd_word;
        endcase
    end

    assign dmem_rdata = (resp_cycle && !err_q && !cmd_q) ? rd_sel : '0;

endmodule
